// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: D = A - B - BIN over WIDTH cycles,
// with one borrow flop carried between bit slices.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BOUT,
    output logic             Z
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bw_q, bw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             z_q, z_d;

    logic a0, b0, dbit, nborrow;

    // Current bit slice: difference bit and borrow into the next slice.
    always_comb begin
        a0      = opa_q[0];
        b0      = opb_q[0];
        dbit    = a0 ^ b0 ^ bw_q;
        nborrow = (~a0 & b0) | (~(a0 ^ b0) & bw_q);
    end

    // Next-state and datapath: load on accepted START, shift one bit per RUN cycle,
    // publish the result on the RUN->FIN transition.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bw_d    = bw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        z_d     = z_q;
        unique case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    opa_d   = A;
                    opb_d   = B;
                    bw_d    = BIN;
                    cnt_d   = '0;
                    work_d  = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                work_d = {dbit, work_q[WIDTH-1:1]};
                opa_d  = {1'b0, opa_q[WIDTH-1:1]};
                opb_d  = {1'b0, opb_q[WIDTH-1:1]};
                bw_d   = nborrow;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // work_d already holds the final bit, so the result is published
                    // on the same edge that enters FIN
                    diff_d  = work_d;
                    bout_d  = nborrow;
                    z_d     = (work_d == '0);
                    state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (R) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bw_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bw_q    <= bw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            z_q     <= z_d;
        end
    end

    assign BUSY = (state_q == RUN);
    assign DONE = (state_q == FIN);
    assign D    = diff_q;
    assign BOUT = bout_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        r, start8, start16, bin8, bin16;
    logic [7:0]  a8, b8, d8;
    logic [15:0] a16, b16, d16;
    logic        busy8, done8, bout8, z8;
    logic        busy16, done16, bout16, z16;

    int checks = 0;
    int errors = 0;

    logic        sel;
    logic        cur_busy, cur_done, cur_bout, cur_z;
    logic [15:0] cur_d;
    assign cur_busy = sel ? busy16 : busy8;
    assign cur_done = sel ? done16 : done8;
    assign cur_bout = sel ? bout16 : bout8;
    assign cur_z    = sel ? z16 : z8;
    assign cur_d    = sel ? d16 : {8'h00, d8};

    serial_subtractor #(.WIDTH(8)) dut8 (
        .CLK(clk), .R(r), .START(start8), .A(a8), .B(b8), .BIN(bin8),
        .BUSY(busy8), .DONE(done8), .D(d8), .BOUT(bout8), .Z(z8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .CLK(clk), .R(r), .START(start16), .A(a16), .B(b16), .BIN(bin16),
        .BUSY(busy16), .DONE(done16), .D(d16), .BOUT(bout16), .Z(z16)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for DONE; returns result and latency.
    task automatic do_op(input logic w16, input logic [15:0] a, input logic [15:0] b,
                         input logic bin, output logic [15:0] d, output logic bout,
                         output logic z, output int lat);
        int          busy_cnt;
        logic        stable;
        logic [15:0] hd;
        logic        hb, hz;
        sel = w16;
        @(negedge clk);
        check("done_one_cycle", cur_done, 1'b0);
        hd = cur_d; hb = cur_bout; hz = cur_z;
        if (w16) begin
            a16 = a; b16 = b; bin16 = bin; start16 = 1'b1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; bin8 = bin; start8 = 1'b1;
        end
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
        busy_cnt = 0; stable = 1'b1; lat = 0;
        while (!cur_done && lat < 64) begin
            if (cur_busy) busy_cnt++;
            if (cur_d !== hd || cur_bout !== hb || cur_z !== hz) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("busy_cycles", busy_cnt, w16 ? 16 : 8);
        check("outputs_stable_in_run", stable, 1'b1);
        check("busy_low_in_fin", cur_busy, 1'b0);
        d = cur_d; bout = cur_bout; z = cur_z;
    endtask

    initial begin
        vec_t        vecs[7];
        logic [15:0] d;
        logic        bout, z, seen;
        int          lat, k;

        vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};

        // Reset with START held: nothing may start.
        r = 1'b1; start8 = 1'b1; start16 = 1'b1; bin8 = 1'b0; bin16 = 1'b0;
        a8 = 8'h5A; b8 = 8'h23; a16 = 16'h1234; b16 = 16'h0001; sel = 1'b0;
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                sel = (i == 1);
                #0;
                check("rst_busy", cur_busy, 1'b0);
                check("rst_done", cur_done, 1'b0);
                check("rst_d", cur_d, 16'h0000);
                check("rst_bout", cur_bout, 1'b0);
                check("rst_z", cur_z, 1'b0);
            end
        end
        start8 = 1'b0; start16 = 1'b0; r = 1'b0;
        @(negedge clk);
        check("idle_after_rst8", busy8, 1'b0);
        check("idle_after_rst16", busy16, 1'b0);

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            do_op(1'b0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].bin, d, bout, z, lat);
            check("vec_latency", lat, 8);
            check("vec_d", d, {8'h00, vecs[i].d});
            check("vec_bout", bout, vecs[i].bout);
            check("vec_z", z, vecs[i].z);
        end

        // START during RUN is ignored.
        sel = 1'b0;
        @(negedge clk);
        a8 = 8'h30; b8 = 8'h10; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; k = 0;
        repeat (2) begin @(negedge clk); k++; end
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1; start8 = 1'b1;
        repeat (2) begin @(negedge clk); k++; end
        start8 = 1'b0;
        while (!done8 && k < 64) begin @(negedge clk); k++; end
        check("ignore_latency", k, 8);
        check("ignore_d", d8, 8'h20);
        check("ignore_bout", bout8, 1'b0);

        // Back-to-back: START accepted in the FIN cycle.
        do_op(1'b0, 16'h005A, 16'h0023, 1'b0, d, bout, z, lat);
        check("b2b_first_d", d, 16'h0037);
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; k = 1;
        check("b2b_busy", busy8, 1'b1);
        check("b2b_done_low", done8, 1'b0);
        while (!done8 && k < 64) begin @(negedge clk); k++; end
        check("b2b_spacing", k, 9);
        check("b2b_d", d8, 8'h7F);
        check("b2b_bout", bout8, 1'b0);

        // Reset mid-operation.
        @(negedge clk);
        a8 = 8'hC3; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        r = 1'b1;
        @(negedge clk);
        r = 1'b0;
        check("abort_busy", busy8, 1'b0);
        check("abort_done", done8, 1'b0);
        check("abort_d", d8, 8'h00);
        check("abort_bout", bout8, 1'b0);
        check("abort_z", z8, 1'b0);
        seen = 1'b0;
        repeat (20) begin @(negedge clk); seen |= done8; end
        check("abort_no_done", seen, 1'b0);
        do_op(1'b0, 16'h00C3, 16'h0011, 1'b0, d, bout, z, lat);
        check("after_abort_d", d, 16'h00B2);
        check("after_abort_lat", lat, 8);

        // Random operands against the arithmetic reference.
        for (int w = 0; w < 2; w++) begin
            for (int n = 0; n < 1000; n++) begin
                logic [15:0] ra, rb;
                logic        rbin;
                int          ai, bi, m, ed;
                logic        eb;
                ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
                if ($urandom_range(0, 9) == 0) rb = ra;
                if (w == 0) begin ra[15:8] = 8'h00; rb[15:8] = 8'h00; end
                ai = int'(ra); bi = int'(rb);
                m  = (w == 1) ? 65536 : 256;
                ed = (((ai - bi - int'(rbin)) % m) + m) % m;
                eb = (ai < bi + int'(rbin));
                do_op(w == 1, ra, rb, rbin, d, bout, z, lat);
                check("rnd_latency", lat, (w == 1) ? 16 : 8);
                check("rnd_d", d, ed[15:0]);
                check("rnd_bout", bout, eb);
                check("rnd_z", z, ed == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
